// File: rtl/tpiu_pkg.sv
// Shared TPIU framing constants and packer state encoding.
package tpiu_pkg;

   localparam int unsigned TPIU_FRAME_WORDS = 8;
   localparam logic [15:0] TPIU_HALFSYNC    = 16'h7FFF;

   typedef enum logic {
      UNSYNC  = 1'b0,
      COLLECT = 1'b1
   } tpiuState_t;

endpackage

// File: rtl/tpiu_skid2.sv
// Two-entry synchronous FIFO; a push while full is ignored unless a pop frees a slot the same cycle.
module tpiu_skid2 #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] rdData_c,
   output logic              full_c,
   output logic              empty_c
);

   logic [DATA_W-1:0] mem [2];
   logic              wrPtr;
   logic              rdPtr;
   logic [1:0]        count;
   logic              doPush;
   logic              doPop;

   assign empty_c  = (count == 2'd0);
   assign full_c   = (count == 2'd2);
   assign rdData_c = mem[rdPtr];
   assign doPop    = pop && !empty_c;
   assign doPush   = push && (!full_c || doPop);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else if (flush) begin
         wrPtr <= 1'b0;
         rdPtr <= 1'b0;
         count <= 2'd0;
      end else begin
         if (doPush) wrPtr <= ~wrPtr;
         if (doPop)  rdPtr <= ~rdPtr;
         count <= count + 2'(doPush) - 2'(doPop);
      end
   end

   // Storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (rst && !flush && doPush) mem[wrPtr] <= wrData;
   end

endmodule

// File: rtl/tpiu_frame_packer.sv
// Packs aligned TPIU half-words into whole 8-word frames for the packet send buffer,
// discarding partial frames with PacketReset and keeping frame/drop statistics.
module tpiu_frame_packer
   import tpiu_pkg::*;
#(
   parameter int unsigned FRAME_WORDS     = TPIU_FRAME_WORDS,
   parameter bit          FILTER_HALFSYNC = 1'b1,
   parameter logic [15:0] HALFSYNC_WORD   = TPIU_HALFSYNC,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      WdIn,
   input  logic             WdInAvail,
   input  logic             SyncIn,
   input  logic             LostSync,
   output logic             WdAvail,
   output logic [15:0]      PacketWd,
   output logic             PacketReset,
   output logic             PacketCommit,
   output logic             Synced,
   output logic [CNT_W-1:0] FrameCount,
   output logic [CNT_W-1:0] DropCount,
   output logic             SkidOverf
);

   localparam int unsigned WORD_W   = 16;
   localparam int unsigned IDX_W    = $clog2(FRAME_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

   tpiuState_t        state, stateNext;
   logic [IDX_W-1:0]  wordIdx, idxNext;
   logic              pendCommit, pendCommitNext;
   logic              pendReset, pendResetNext;
   logic              wdAvailNext;
   logic [WORD_W-1:0] packetWdNext;
   logic              packetResetNext;
   logic              packetCommitNext;
   logic              syncedNext;
   logic [CNT_W-1:0]  frameCountNext;
   logic [CNT_W-1:0]  dropCountNext;
   logic              skidOverfNext;
   logic              dropInc;
   logic              accept;
   logic              canEmit;
   logic              partial;

   logic              skidPush, skidPop, skidFlush;
   logic [WORD_W-1:0] skidHead;
   logic              skidFull, skidEmpty;

   tpiu_skid2 #(.DATA_W(WORD_W)) uSkid (
      .clk      (clk),
      .rst      (rst),
      .push     (skidPush),
      .pop      (skidPop),
      .flush    (skidFlush),
      .wrData   (WdIn),
      .rdData_c (skidHead),
      .full_c   (skidFull),
      .empty_c  (skidEmpty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= UNSYNC;
         wordIdx      <= '0;
         pendCommit   <= 1'b0;
         pendReset    <= 1'b0;
         WdAvail      <= 1'b0;
         PacketWd     <= '0;
         PacketReset  <= 1'b0;
         PacketCommit <= 1'b0;
         Synced       <= 1'b0;
         FrameCount   <= '0;
         DropCount    <= '0;
         SkidOverf    <= 1'b0;
      end else begin
         state        <= stateNext;
         wordIdx      <= idxNext;
         pendCommit   <= pendCommitNext;
         pendReset    <= pendResetNext;
         WdAvail      <= wdAvailNext;
         PacketWd     <= packetWdNext;
         PacketReset  <= packetResetNext;
         PacketCommit <= packetCommitNext;
         Synced       <= syncedNext;
         FrameCount   <= frameCountNext;
         DropCount    <= dropCountNext;
         SkidOverf    <= skidOverfNext;
      end
   end

   always_comb begin
      stateNext        = state;
      idxNext          = wordIdx;
      pendCommitNext   = pendCommit;
      pendResetNext    = pendReset;
      wdAvailNext      = 1'b0;
      packetWdNext     = '0;
      packetResetNext  = 1'b0;
      packetCommitNext = 1'b0;
      syncedNext       = Synced;
      frameCountNext   = FrameCount;
      skidOverfNext    = 1'b0;
      dropInc          = 1'b0;
      skidPush         = 1'b0;
      skidPop          = 1'b0;
      skidFlush        = 1'b0;
      accept           = 1'b0;
      canEmit          = 1'b0;
      partial          = (wordIdx != '0) || !skidEmpty;

      // Queued strobes go out one per cycle ahead of any data, commit first.
      if (pendCommit) begin
         packetCommitNext = 1'b1;
         pendCommitNext   = 1'b0;
         frameCountNext   = FrameCount + CNT_W'(1);
         syncedNext       = 1'b1;
      end else if (pendReset) begin
         packetResetNext = 1'b1;
         pendResetNext   = 1'b0;
      end

      if (LostSync) begin
         if (partial) begin
            skidFlush     = 1'b1;
            pendResetNext = 1'b1;
            dropInc       = 1'b1;
         end
         idxNext    = '0;
         stateNext  = UNSYNC;
         syncedNext = 1'b0;
      end else if (SyncIn) begin
         if (state == UNSYNC) begin
            pendResetNext = 1'b1;
            stateNext     = COLLECT;
            idxNext       = '0;
         end else if (partial) begin
            skidFlush     = 1'b1;
            pendResetNext = 1'b1;
            dropInc       = 1'b1;
            idxNext       = '0;
         end
      end else if (state == COLLECT) begin
         accept  = WdInAvail && !(FILTER_HALFSYNC && (WdIn == HALFSYNC_WORD));
         canEmit = !(pendCommit || pendReset);
         // An empty skid lets the incoming word bypass straight to the output.
         if (canEmit && (!skidEmpty || accept)) begin
            wdAvailNext  = 1'b1;
            packetWdNext = skidEmpty ? WdIn : skidHead;
            skidPop      = !skidEmpty;
            if (wordIdx == LAST_IDX) begin
               idxNext        = '0;
               pendCommitNext = 1'b1;
            end else begin
               idxNext = wordIdx + IDX_W'(1);
            end
         end
         skidPush = accept && !(canEmit && skidEmpty);
         if (skidPush && skidFull && !skidPop) begin
            skidOverfNext = 1'b1;
            dropInc       = 1'b1;
         end
      end

      dropCountNext = (dropInc && (DropCount != '1)) ? DropCount + CNT_W'(1) : DropCount;
   end

endmodule
